// File: rtl/spi_ram_responder.sv
// rtl/spi_ram_responder.sv - SPI mode-0 serial SRAM responder with backdoor preload
//
// Purpose: emulates a serial SRAM on an SPI bus. The SPI pins are
// oversampled by clk. READ (0x03) and WRITE (0x02) commands with a 16-bit
// address are decoded. Bytes are served from an internal array.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   rst        synchronous active-high reset
//   sclk       SPI clock from the master (asynchronous)
//   cs_n       SPI chip select, active low (asynchronous)
//   mosi       serial data from the master, MSB first
//   miso       serial data to the master
//   miso_oe    high while miso is driven (read data phase)
//   active     high while a transaction is selected
//   load_en    backdoor write strobe
//   load_addr  backdoor address
//   load_data  backdoor data
module spi_ram_responder #(
  parameter int         ADDR_BITS = 8,
  parameter logic [7:0] READ_CMD  = 8'h03,
  parameter logic [7:0] WRITE_CMD = 8'h02
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 cs_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  output logic                 active,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR_H,
    S_ADDR_L,
    S_READ,
    S_WRITE,
    S_IGNORE
  } state_e;

  state_e state_q, state_d;

  // Synchronizers and edge detection
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic cs_s1_q, cs_s2_q;
  logic mosi_s1_q, mosi_s2_q;
  logic rise_q, fall_q;

  // After reset the cs_n synchronizer holds its idle level for two clocks.
  // A transaction may only start once a genuinely synchronized high cs_n has
  // been seen. This prevents an abort by reset from resuming a transaction
  // that is still selected.
  logic [1:0] post_rst_q;
  logic       armed_q;

  // Datapath
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_in_q, shift_in_d;
  logic [7:0]  shift_out_q, shift_out_d;
  logic [15:0] addr_q, addr_d;
  logic        is_read_q, is_read_d;
  logic        miso_q, miso_d;
  logic        miso_oe_q, miso_oe_d;

  logic [7:0]  mem_q [DEPTH];

  logic        byte_done;
  logic [7:0]  rx_byte;
  logic [15:0] addr_l_full;
  logic [15:0] addr_inc;
  logic        spi_we;

  assign byte_done   = rise_q && (bit_cnt_q == 3'd7);
  assign rx_byte     = {shift_in_q[6:0], mosi_s2_q};
  assign addr_l_full = {addr_q[15:8], rx_byte};
  assign addr_inc    = addr_q + 16'd1;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_s3_q   <= 1'b0;
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      post_rst_q  <= 2'b00;
      armed_q     <= 1'b0;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 8'd0;
      shift_out_q <= 8'd0;
      addr_q      <= 16'd0;
      is_read_q   <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_s1_q   <= sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_s3_q   <= sclk_s2_q;
      cs_s1_q     <= cs_n;
      cs_s2_q     <= cs_s1_q;
      mosi_s1_q   <= mosi;
      mosi_s2_q   <= mosi_s1_q;
      rise_q      <= sclk_s2_q & ~sclk_s3_q;
      fall_q      <= ~sclk_s2_q & sclk_s3_q;
      post_rst_q  <= {post_rst_q[0], 1'b1};
      armed_q     <= armed_q | (post_rst_q[1] & cs_s2_q);
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      addr_q      <= addr_d;
      is_read_q   <= is_read_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
    end
  end

  // Byte array. The SPI write is applied after the backdoor write so that it
  // wins on an address collision.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
    if (spi_we) begin
      mem_q[addr_q[ADDR_BITS-1:0]] <= rx_byte;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (cs_s2_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (armed_q) state_d = S_CMD;
        end
        S_CMD: begin
          if (byte_done) begin
            if (rx_byte == READ_CMD || rx_byte == WRITE_CMD) state_d = S_ADDR_H;
            else                                            state_d = S_IGNORE;
          end
        end
        S_ADDR_H: begin
          if (byte_done) state_d = S_ADDR_L;
        end
        S_ADDR_L: begin
          if (byte_done) state_d = is_read_q ? S_READ : S_WRITE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    addr_d      = addr_q;
    is_read_d   = is_read_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    spi_we      = 1'b0;

    if (cs_s2_q || state_q == S_IDLE) begin
      // Deselected: drop any partial byte and release miso
      bit_cnt_d  = 3'd0;
      shift_in_d = 8'd0;
      miso_d     = 1'b0;
      miso_oe_d  = 1'b0;
    end else begin
      if (rise_q) begin
        bit_cnt_d  = bit_cnt_q + 3'd1;
        shift_in_d = rx_byte;
      end
      case (state_q)
        S_CMD: begin
          if (byte_done) is_read_d = (rx_byte == READ_CMD);
        end
        S_ADDR_H: begin
          if (byte_done) addr_d = {rx_byte, addr_q[7:0]};
        end
        S_ADDR_L: begin
          if (byte_done) begin
            addr_d = addr_l_full;
            if (is_read_q) shift_out_d = mem_q[addr_l_full[ADDR_BITS-1:0]];
          end
        end
        S_READ: begin
          if (fall_q) begin
            miso_d      = shift_out_q[7];
            miso_oe_d   = 1'b1;
            shift_out_d = {shift_out_q[6:0], 1'b0};
          end
          // The full 16-bit address increments, but only the low ADDR_BITS
          // index the array, so the access wraps modulo the depth.
          if (byte_done) begin
            addr_d      = addr_inc;
            shift_out_d = mem_q[addr_inc[ADDR_BITS-1:0]];
          end
        end
        S_WRITE: begin
          if (byte_done) begin
            spi_we = 1'b1;
            addr_d = addr_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    miso    = miso_q;
    miso_oe = miso_oe_q;
    active  = (state_q != S_IDLE);
  end

endmodule
